// File: rtl/rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rx_deframer
// Purpose  : HDLC-style receive deframer (flag hunt, zero-bit deletion, abort)
//            delivering bytes through a single receive holding register.
// Revision : 1.0
// ============================================================================
module rx_deframer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        netclk,
    input  logic        rxdata,
    input  logic        enable,
    output logic [15:0] rx_word,
    output logic        rx_word_available,
    input  logic        rx_strobe,
    output logic        overrun,
    output logic        in_frame
);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_SYNC  = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    localparam logic [15:0] ERR_WORD = 16'hA000;

    logic [SYNC_STAGES-1:0] netclk_sync_q;
    logic [SYNC_STAGES-1:0] rxdata_sync_q;
    logic                   netclk_prev_q;
    logic                   bit_evt_q;
    logic                   bit_val_q;

    state_t      state_q;
    logic [2:0]  ones_q;
    logic [5:0]  dl_q;
    logic [2:0]  dl_cnt_q;
    logic [6:0]  asm_q;
    logic [2:0]  asm_cnt_q;
    logic [7:0]  pend_q;
    logic        pend_vld_q;
    logic        enable_prev_q;
    logic        strobe_prev_q;
    logic [15:0] rx_word_q;
    logic        avail_q;
    logic        overrun_q;

    logic [2:0]  ones_d;
    logic [5:0]  dl_d;
    logic [7:0]  asm_d;
    logic        is_flag;
    logic        is_abort;
    logic        is_data;
    logic        dl_full;
    logic        byte_done;
    logic        enable_rise;
    logic        strobe_edge;
    logic        accept;
    logic        push;
    logic [15:0] push_word;

    // Bit events are registered so every later decision sees a stable bit value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            netclk_sync_q <= '0;
            rxdata_sync_q <= '0;
            netclk_prev_q <= 1'b0;
            bit_evt_q     <= 1'b0;
            bit_val_q     <= 1'b0;
        end else begin
            netclk_sync_q <= {netclk_sync_q[SYNC_STAGES-2:0], netclk};
            rxdata_sync_q <= {rxdata_sync_q[SYNC_STAGES-2:0], rxdata};
            netclk_prev_q <= netclk_sync_q[SYNC_STAGES-1];
            bit_evt_q     <= netclk_sync_q[SYNC_STAGES-1] & ~netclk_prev_q;
            bit_val_q     <= rxdata_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        ones_d = 3'd0;
        if (bit_val_q) begin
            ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
        end
        is_flag     = !bit_val_q && (ones_q == 3'd6);
        is_abort    = bit_val_q && (ones_q >= 3'd6);
        is_data     = bit_val_q ? (ones_q < 3'd5)
                                : ((ones_q != 3'd5) && (ones_q != 3'd6));
        dl_full     = (dl_cnt_q == 3'd6);
        dl_d        = {dl_q[4:0], bit_val_q};
        asm_d       = {dl_q[5], asm_q};
        byte_done   = dl_full && (asm_cnt_q == 3'd7);
        enable_rise = enable && !enable_prev_q;
        strobe_edge = rx_strobe && !strobe_prev_q;
        accept      = bit_evt_q && enable && !enable_rise;

        push      = 1'b0;
        push_word = 16'h0000;
        if (accept && (state_q == S_FRAME)) begin
            if (is_abort) begin
                push      = 1'b1;
                push_word = ERR_WORD;
            end else if (is_flag) begin
                if (asm_cnt_q != 3'd0) begin
                    push      = 1'b1;
                    push_word = ERR_WORD;
                end else if (pend_vld_q) begin
                    push      = 1'b1;
                    push_word = {8'hC0, pend_q};
                end
            end else if (is_data && byte_done && pend_vld_q) begin
                push      = 1'b1;
                push_word = {8'h40, pend_q};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_HUNT;
            ones_q        <= 3'd0;
            dl_q          <= 6'd0;
            dl_cnt_q      <= 3'd0;
            asm_q         <= 7'd0;
            asm_cnt_q     <= 3'd0;
            pend_q        <= 8'd0;
            pend_vld_q    <= 1'b0;
            enable_prev_q <= 1'b0;
            strobe_prev_q <= 1'b0;
            rx_word_q     <= 16'h0000;
            avail_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            enable_prev_q <= enable;
            strobe_prev_q <= rx_strobe;

            // A push beats a simultaneous read strobe: the new word stays available.
            if (enable_rise) begin
                rx_word_q <= 16'h0000;
                avail_q   <= 1'b0;
                overrun_q <= 1'b0;
            end else if (push) begin
                rx_word_q <= push_word;
                avail_q   <= 1'b1;
                if (avail_q && !strobe_edge) begin
                    overrun_q <= 1'b1;
                end
            end else if (strobe_edge) begin
                avail_q <= 1'b0;
            end

            if (!enable || enable_rise) begin
                state_q <= S_HUNT;
                ones_q  <= 3'd0;
            end else if (bit_evt_q) begin
                ones_q <= ones_d;
                case (state_q)
                    S_HUNT: begin
                        if (is_flag) begin
                            state_q <= S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        if (is_abort) begin
                            state_q <= S_HUNT;
                        end else if (is_data) begin
                            state_q    <= S_FRAME;
                            dl_q       <= {5'd0, bit_val_q};
                            dl_cnt_q   <= 3'd1;
                            asm_q      <= 7'd0;
                            asm_cnt_q  <= 3'd0;
                            pend_vld_q <= 1'b0;
                        end
                    end
                    S_FRAME: begin
                        if (is_abort || is_flag) begin
                            // The delay line now holds the flag/abort prefix, never payload.
                            state_q    <= is_abort ? S_HUNT : S_SYNC;
                            dl_cnt_q   <= 3'd0;
                            asm_cnt_q  <= 3'd0;
                            pend_vld_q <= 1'b0;
                        end else if (is_data) begin
                            dl_q <= dl_d;
                            if (!dl_full) begin
                                dl_cnt_q <= dl_cnt_q + 3'd1;
                            end else begin
                                asm_q     <= asm_d[7:1];
                                asm_cnt_q <= asm_cnt_q + 3'd1;
                                if (asm_cnt_q == 3'd7) begin
                                    pend_q     <= asm_d;
                                    pend_vld_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= S_HUNT;
                endcase
            end
        end
    end

    assign rx_word           = rx_word_q;
    assign rx_word_available = avail_q;
    assign overrun           = overrun_q;
    assign in_frame          = (state_q == S_FRAME);

endmodule
`default_nettype wire

// File: tb/tb_rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rx_deframer
// Purpose  : Self-checking bench: HDLC encoder plus frame-level word model.
// Revision : 1.0
// ============================================================================
module tb_rx_deframer;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        netclk    = 1'b0;
    logic        rxdata    = 1'b0;
    logic        enable    = 1'b0;
    logic        rx_strobe = 1'b0;
    logic [15:0] rx_word;
    logic        rx_word_available;
    logic        overrun;
    logic        in_frame;

    int          checks  = 0;
    int          errors  = 0;
    logic [15:0] exp_q[$];
    bit          fb[$];
    bit          cmp_en      = 1'b0;
    bit          auto_strobe = 1'b0;
    int          req_cnt = 0;
    int          ack_cnt = 0;
    logic        avail_prev = 1'b0;
    int          k_lat;

    always #5 clk = ~clk;

    rx_deframer #(.SYNC_STAGES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .netclk            (netclk),
        .rxdata            (rxdata),
        .enable            (enable),
        .rx_word           (rx_word),
        .rx_word_available (rx_word_available),
        .rx_strobe         (rx_strobe),
        .overrun           (overrun),
        .in_frame          (in_frame)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Sole driver of rx_strobe: one-cycle pulses, either on request or automatically.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rx_strobe) begin
                rx_strobe = 1'b0;
            end else if (req_cnt != ack_cnt) begin
                rx_strobe = 1'b1;
                ack_cnt++;
            end else if (auto_strobe && rx_word_available) begin
                rx_strobe = 1'b1;
            end
        end
    end

    initial begin
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (cmp_en && rx_word_available && !avail_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h want none", rx_word);
                end else begin
                    w = exp_q.pop_front();
                    check("rhr_word", rx_word, w);
                    check("no_overrun", 16'(overrun), 16'h0);
                end
            end
            avail_prev = rx_word_available;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        netclk = 1'b0;
        rxdata = b;
        repeat (3) @(negedge clk);
        netclk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
    endtask

    task automatic send_abort();
        repeat (7) send_bit(1'b1);
    endtask

    // Transmitter side: insert a 0 after every five consecutive 1s of payload.
    task automatic send_payload();
        int ones;
        ones = 0;
        foreach (fb[i]) begin
            send_bit(fb[i]);
            if (fb[i]) begin
                ones++;
                if (ones == 5) begin
                    send_bit(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) fb.push_back(v[i]);
    endtask

    function automatic logic [7:0] fb_byte(input int idx);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = fb[8*idx + j];
        return v;
    endfunction

    // Frame closed by a flag: whole bytes delivered, last one tagged eop,
    // a trailing partial byte turns the tail into a single error word.
    task automatic model_flag_close();
        int n;
        int full;
        n    = fb.size();
        full = n / 8;
        if (n == 0) return;
        for (int i = 0; i < full - 1; i++) exp_q.push_back({8'h40, fb_byte(i)});
        if (n % 8 == 0) exp_q.push_back({8'hC0, fb_byte(full - 1)});
        else            exp_q.push_back(16'hA000);
    endtask

    // Abort after k whole bytes: the last two bytes are still in flight and lost.
    task automatic model_abort_close();
        int k;
        k = fb.size() / 8;
        for (int i = 0; i < k - 2; i++) exp_q.push_back({8'h40, fb_byte(i)});
        exp_q.push_back(16'hA000);
    endtask

    task automatic drain_check(input string name);
        repeat (10) @(negedge clk);
        check(name, 16'(exp_q.size()), 16'h0);
    endtask

    initial begin
        logic [11:0] tw;
        int kind;
        int n;

        repeat (3) @(negedge clk);
        check("reset_word", rx_word, 16'h0);
        check("reset_avail", 16'(rx_word_available), 16'h0);
        check("reset_overrun", 16'(overrun), 16'h0);
        check("reset_in_frame", 16'(in_frame), 16'h0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        cmp_en      = 1'b1;
        auto_strobe = 1'b1;
        send_flag();
        send_flag();

        // Two-byte frame
        exp_q.push_back(16'h4012);
        exp_q.push_back(16'hC034);
        fb.delete();
        add_byte(8'h12);
        add_byte(8'h34);
        send_flag();
        send_payload();
        check("t1_in_frame_mid", 16'(in_frame), 16'h1);
        send_flag();
        check("t1_in_frame_after", 16'(in_frame), 16'h0);
        drain_check("t1_drained");
        check("t1_overrun", 16'(overrun), 16'h0);

        // Byte needing a stuffed zero
        exp_q.push_back(16'hC0FF);
        fb.delete();
        add_byte(8'hFF);
        send_flag();
        send_payload();
        send_flag();
        drain_check("t2_drained");

        // Abort after one byte
        exp_q.push_back(16'hA000);
        fb.delete();
        add_byte(8'hA5);
        send_flag();
        send_payload();
        send_abort();
        check("t3_in_frame", 16'(in_frame), 16'h0);
        drain_check("t3_drained");
        send_flag();

        // Overrun with no reads, then enable rising edge clears it
        cmp_en      = 1'b0;
        auto_strobe = 1'b0;
        fb.delete();
        add_byte(8'h11);
        add_byte(8'h22);
        add_byte(8'h33);
        send_flag();
        send_payload();
        send_flag();
        repeat (4) @(negedge clk);
        check("t4_overrun_set", 16'(overrun), 16'h1);
        check("t4_word", rx_word, 16'hC033);
        check("t4_avail", 16'(rx_word_available), 16'h1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_overrun_clr", 16'(overrun), 16'h0);
        check("t4_avail_clr", 16'(rx_word_available), 16'h0);
        check("t4_word_clr", rx_word, 16'h0);
        cmp_en      = 1'b1;
        auto_strobe = 1'b1;

        // Twelve data bits, then a clean frame
        exp_q.push_back(16'hA000);
        exp_q.push_back(16'hC055);
        fb.delete();
        tw = 12'hB6D;
        for (int i = 0; i < 12; i++) fb.push_back(tw[i]);
        send_flag();
        send_payload();
        send_flag();
        fb.delete();
        add_byte(8'h55);
        send_payload();
        send_flag();
        drain_check("t5_drained");

        // Measure push latency from the closing flag's last netclk edge
        cmp_en      = 1'b0;
        auto_strobe = 1'b0;
        repeat (4) @(negedge clk);
        fb.delete();
        add_byte(8'h3C);
        send_flag();
        send_payload();
        for (int i = 0; i < 7; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        @(negedge clk);
        netclk = 1'b0;
        rxdata = 1'b0;
        repeat (3) @(negedge clk);
        netclk = 1'b1;
        k_lat  = 0;
        while (!rx_word_available && k_lat < 30) begin
            @(negedge clk);
            k_lat++;
        end
        check("t6_calib_avail", 16'(rx_word_available), 16'h1);
        check("t6_calib_word", rx_word, 16'hC03C);
        if (k_lat < 1 || k_lat >= 30) k_lat = 4;

        // Read strobe lands in the very cycle of the push into a full RHR
        fb.delete();
        add_byte(8'h5A);
        send_flag();
        send_payload();
        for (int i = 0; i < 7; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        @(negedge clk);
        netclk = 1'b0;
        rxdata = 1'b0;
        repeat (3) @(negedge clk);
        netclk = 1'b1;
        repeat (k_lat - 1) @(negedge clk);
        req_cnt++;
        repeat (4) @(negedge clk);
        check("t6_coinc_avail", 16'(rx_word_available), 16'h1);
        check("t6_coinc_overrun", 16'(overrun), 16'h0);
        check("t6_coinc_word", rx_word, 16'hC05A);
        req_cnt++;
        repeat (4) @(negedge clk);
        check("t6_strobe_clears", 16'(rx_word_available), 16'h0);
        check("t6_word_held", rx_word, 16'hC05A);

        // Reset in the middle of a frame
        fb.delete();
        add_byte(8'h77);
        for (int i = 0; i < 4; i++) fb.push_back(1'b1);
        send_flag();
        send_payload();
        #2 reset = 1'b1;
        #1;
        check("t7_rst_word", rx_word, 16'h0);
        check("t7_rst_avail", 16'(rx_word_available), 16'h0);
        check("t7_rst_overrun", 16'(overrun), 16'h0);
        check("t7_rst_in_frame", 16'(in_frame), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        cmp_en      = 1'b1;
        auto_strobe = 1'b1;
        exp_q.push_back(16'hC099);
        fb.delete();
        add_byte(8'h99);
        send_flag();
        send_flag();
        send_payload();
        send_flag();
        drain_check("t7_drained");

        // Randomized frames checked against the frame-level model
        for (int it = 0; it < 30; it++) begin
            fb.delete();
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(1, 4);
                    for (int b = 0; b < n; b++) add_byte(8'($urandom()));
                    model_flag_close();
                end
                1: begin
                    n = $urandom_range(1, 30);
                    if (n % 8 == 0) n++;
                    for (int b = 0; b < n; b++) fb.push_back(1'($urandom()));
                    model_flag_close();
                end
                2: begin
                    n = $urandom_range(0, 3);
                    for (int b = 0; b < n; b++) add_byte(8'($urandom()));
                    model_abort_close();
                end
                default: model_flag_close();
            endcase
            send_flag();
            send_payload();
            if (kind == 2) send_abort();
            else           send_flag();
            send_flag();
            drain_check("rand_drained");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
